// File: rtl/rho_lane_rotator_pkg.sv
// Shared constants, FSM encoding and request payload for the rho lane rotator.
// RHO_OFFSET_LUT_EN: when defined, exposes the rho triangular-number table.
package rho_lane_rotator_pkg;

   localparam int unsigned IDX_W     = 5;
   localparam int unsigned NUM_LANES = 25;
   localparam int unsigned T_MAX     = 23;
   localparam int unsigned TRI_W     = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_CAP  = 2'd2,
      ST_WR   = 2'd3
   } state_e;

   // Latched request: lane address plus out-of-range flag.
   typedef struct packed {
      logic             bad;
      logic [IDX_W-1:0] lane;
   } lane_req_t;

`ifdef RHO_OFFSET_LUT_EN
   // (t+1)(t+2)/2 for t = 0..23, kept un-reduced so any power-of-two LANE_W works.
   localparam logic [TRI_W-1:0] RHO_TRI [T_MAX+1] = '{
      10'd1,   10'd3,   10'd6,   10'd10,  10'd15,  10'd21,
      10'd28,  10'd36,  10'd45,  10'd55,  10'd66,  10'd78,
      10'd91,  10'd105, 10'd120, 10'd136, 10'd153, 10'd171,
      10'd190, 10'd210, 10'd231, 10'd253, 10'd276, 10'd300
   };
`endif

endpackage

// File: rtl/rho_lane_rotator_offset_calc.sv
// Combinational tIdx -> rho rotation offset (mod LANE_W); t > 23 yields 0.
// RHO_OFFSET_LUT_EN selects the table path, otherwise arithmetic; results identical.
module rho_lane_rotator_offset_calc
   import rho_lane_rotator_pkg::*;
#(
   parameter int unsigned LANE_W = 64,
   parameter int unsigned T_W    = 5
) (
   input  logic [T_W-1:0]            t_i,
   output logic [$clog2(LANE_W)-1:0] off_c
);

   localparam int unsigned OFF_W = $clog2(LANE_W);

`ifdef RHO_OFFSET_LUT_EN
   logic [IDX_W-1:0] t_sel;

   // Table lookup; reduction mod LANE_W is the truncation to OFF_W.
   always_comb begin
      off_c = '0;
      t_sel = IDX_W'(t_i);
      if (32'(t_i) <= T_MAX) begin
         off_c = OFF_W'(RHO_TRI[t_sel]);
      end
   end
`else
   logic [TRI_W-1:0] t1;

   // (t+1)(t+2)/2 at 10 bits, then truncated to OFF_W for the mod.
   always_comb begin
      off_c = '0;
      t1    = TRI_W'(t_i) + TRI_W'(1);
      if (32'(t_i) <= T_MAX) begin
         off_c = OFF_W'((t1 * (t1 + TRI_W'(1))) >> 1);
      end
   end
`endif

endmodule

// File: rtl/rho_lane_rotator.sv
// Reads one lane, rotates it left by the rho offset of t, and writes it back.
// Four-state walk IDLE -> RD -> CAP -> WR; strobes are decoded from state.
// RHO_OFFSET_LUT_EN: selects the table-based offset path (bit-identical outputs).
module rho_lane_rotator
   import rho_lane_rotator_pkg::*;
#(
   parameter int unsigned LANE_W = 64,
   parameter int unsigned T_W    = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              idxValid,
   output logic              idxReady,
   input  logic [IDX_W-1:0]  laneIdx,
   input  logic [T_W-1:0]    tIdx,
   output logic [IDX_W-1:0]  memAddr,
   output logic              memRdEn,
   input  logic [LANE_W-1:0] memRdData,
   output logic              memWrEn,
   output logic [LANE_W-1:0] memWrData,
   output logic              busy,
   output logic              done,
   output logic              idxErr
);

   localparam int unsigned OFF_W = $clog2(LANE_W);

   state_e            state_q, state_d;
   lane_req_t         req_q, req_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic              err_q, err_d;
   logic [OFF_W-1:0]  off_c;

   // Rotate left; a zero offset passes through so we never shift by LANE_W.
   function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] x,
                                               input logic [OFF_W-1:0]  s);
      if (s == '0) begin
         return x;
      end
      return (x << s) | (x >> (32'(LANE_W) - 32'(s)));
   endfunction

   rho_lane_rotator_offset_calc #(
      .LANE_W (LANE_W),
      .T_W    (T_W)
   ) u_offset_calc (
      .t_i   (tIdx),
      .off_c (off_c)
   );

   // Next-state and datapath latch selection.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      off_d   = off_q;
      lane_d  = lane_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (idxValid) begin
               req_d.lane = laneIdx;
               req_d.bad  = (32'(laneIdx) > (NUM_LANES - 1));
               off_d      = off_c;
               err_d      = err_q | req_d.bad;
               state_d    = ST_RD;
            end
         end
         ST_RD:   state_d = ST_CAP;
         ST_CAP: begin
            lane_d  = rotl(memRdData, off_q);
            state_d = ST_WR;
         end
         ST_WR:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         off_q   <= '0;
         lane_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         off_q   <= off_d;
         lane_q  <= lane_d;
         err_q   <= err_d;
      end
   end

   // Strobes decoded from the state register; bad indices suppress RAM access.
   always_comb begin
      idxReady  = (state_q == ST_IDLE);
      busy      = (state_q != ST_IDLE);
      memRdEn   = (state_q == ST_RD) && !req_q.bad;
      memWrEn   = (state_q == ST_WR) && !req_q.bad;
      done      = (state_q == ST_WR);
      memAddr   = req_q.lane;
      memWrData = lane_q;
      idxErr    = err_q;
   end

endmodule
